dmem_mmio_responder: RTL and testbench

- Responder end of the core's data-memory interface.
- The core drives the address (its ALU result), MemWrite and writedata, and expects ReadData in the same cycle.
- This block decodes that address into a word RAM region and an MMIO region.
- The MMIO region holds a byte-wide TX FIFO with a valid/ready drain port and a free-running 64-bit cycle counter.
- It sits beside the single-cycle core at top level.

---
 rtl/dmem_mmio_responder_pkg.sv | 20 ++
 rtl/dmem_mmio_responder_tx_fifo.sv | 74 +++++++
 rtl/dmem_mmio_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared MMIO map and STATUS bit layout for dmem_mmio_responder.
// Combinational-only constants; no latency or backpressure of its own.
package dmem_mmio_responder_pkg;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

  localparam logic [7:0] OFF_TXDATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
  localparam logic [7:0] OFF_ERRADDR  = 8'h10;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_BUS_ERR = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 4;

endpackage

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Synchronous circular FIFO: head entry is registered, visible one cycle after the push edge.
// Push accepted when not full or when a pop frees a slot that cycle; head holds while out_vld && !out_rdy.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_vld,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     in_rdy,
  output logic                     out_vld,
  output logic [WIDTH-1:0]         out_dat,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    out_vld = !empty;
    out_dat = mem_q[rd_ptr_q];
    count   = count_q;
    pop     = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    in_rdy  = !full || pop;
    push    = in_vld && in_rdy;

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus MMIO page (TX FIFO, 64-bit cycle counter); reads combinational, writes on clk.
// Optional DMEM_BUS_ERR_EN adds sticky STATUS bus_err and ERRADDR; TX drain is valid/ready, full pushes drop and set overflow.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        MemWrite,
  input  logic [31:0] writedata,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [63:0]       cycle_q, cycle_d;
  logic              ovf_q, ovf_d;

  logic              ram_hit, mmio_hit;
  logic [7:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we, txd_wr, sts_wr;

  logic              fifo_in_rdy, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status;

  always_comb begin
    ram_hit  = ({1'b0, addr} < RAM_BYTES);
    mmio_hit = !ram_hit && (addr[31:8] == MMIO_BASE[31:8]);
    off      = addr[7:0] & 8'hFC;
    ram_idx  = addr[RAM_AW+1:2];
    ram_we   = MemWrite && ram_hit;
    txd_wr   = MemWrite && mmio_hit && (off == OFF_TXDATA);
    sts_wr   = MemWrite && mmio_hit && (off == OFF_STATUS);
  end

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (txd_wr),
    .in_dat  (writedata[7:0]),
    .in_rdy  (fifo_in_rdy),
    .out_vld (tx_valid),
    .out_dat (tx_data),
    .out_rdy (tx_ready),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A dropped push sets overflow after any clear, so set wins on a same-cycle collision.
  always_comb begin
    ovf_d = ovf_q;
    if (sts_wr && writedata[ST_OVF]) ovf_d = 1'b0;
    if (txd_wr && !fifo_in_rdy)      ovf_d = 1'b1;
    cycle_d = cycle_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= writedata;
  end

`ifdef DMEM_BUS_ERR_EN
  logic        err_q, err_d;
  logic [31:0] erraddr_q, erraddr_d;
  logic        err_hit;

  always_comb begin
    err_hit   = (!ram_hit && !mmio_hit) ||
                (MemWrite && mmio_hit && (off != OFF_TXDATA) && (off != OFF_STATUS));
    err_d     = err_q;
    erraddr_d = erraddr_q;
    if (sts_wr && writedata[ST_BUS_ERR]) err_d = 1'b0;
    if (err_hit) begin
      err_d = 1'b1;
      if (!err_q) erraddr_d = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      erraddr_q <= '0;
    end else begin
      err_q     <= err_d;
      erraddr_q <= erraddr_d;
    end
  end
`endif

  always_comb begin
    status                          = '0;
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = ovf_q;
`ifdef DMEM_BUS_ERR_EN
    status[ST_BUS_ERR]              = err_q;
`else
    status[ST_BUS_ERR]              = 1'b0;
`endif
    status[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = ram_q[ram_idx];
    end else if (mmio_hit) begin
      unique case (off)
        OFF_TXDATA:   ReadData = '0;
        OFF_STATUS:   ReadData = status;
        OFF_CYCLE_LO: ReadData = cycle_q[31:0];
        OFF_CYCLE_HI: ReadData = cycle_q[63:32];
`ifdef DMEM_BUS_ERR_EN
        OFF_ERRADDR:  ReadData = erraddr_q;
`else
        OFF_ERRADDR:  ReadData = '0;
`endif
        default:      ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized plus directed bench for dmem_mmio_responder against a queue/array reference model.
module tb_dmem_mmio_responder;
  import dmem_mmio_responder_pkg::*;

  localparam int          RAM_WORDS  = 1024;
  localparam int          FIFO_DEPTH = 8;
  localparam logic [31:0] MB         = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        MemWrite;
  logic [31:0] writedata;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_mmio_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .MemWrite  (MemWrite),
    .writedata (writedata),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // Reference model state
  logic [31:0]  ram_m [RAM_WORDS];
  bit           ram_ok [RAM_WORDS];
  byte unsigned fq[$];
  bit           ovf_m;
  bit           err_m;
  logic [31:0]  ea_m;
  logic [63:0]  cyc_m;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'(RAM_WORDS * 4);
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return !is_ram(a) && (a[31:8] == MB[31:8]);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    logic [31:0] v;
    int          w;
    logic [7:0]  o;
    known = 1'b1;
    v     = '0;
    o     = a[7:0] & 8'hFC;
    if (is_ram(a)) begin
      w     = int'(a >> 2);
      known = ram_ok[w];
      v     = ram_m[w];
    end else if (is_mmio(a)) begin
      case (o)
        8'h04: v = {24'd0, 4'(fq.size()), err_m, ovf_m,
                    fq.size() == 0, fq.size() == FIFO_DEPTH};
        8'h08: v = cyc_m[31:0];
        8'h0C: v = cyc_m[63:32];
`ifdef DMEM_BUS_ERR_EN
        8'h10: v = ea_m;
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    fq.delete();
    ovf_m = 1'b0;
    err_m = 1'b0;
    ea_m  = '0;
    cyc_m = '0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic step(input logic [31:0] a, input bit we, input logic [31:0] wd,
                      input bit rdy, input bit rst = 1'b0);
    logic [31:0] ev;
    bit          known, pop, full, tx_w, st_w, bad;
    logic [7:0]  o;
    addr = a; MemWrite = we; writedata = wd; tx_ready = rdy; reset = rst;
    #1;
    ev = model_read(a, known);
    if (known) check_val("rdata", ReadData, ev);
    check_val("tx_valid", tx_valid, fq.size() != 0);
    if (fq.size() != 0) check_val("tx_data", tx_data, fq[0]);
    @(posedge clk);
    if (we && is_ram(a)) begin
      ram_m[int'(a >> 2)]  = wd;
      ram_ok[int'(a >> 2)] = 1'b1;
    end
    if (rst) begin
      model_reset();
    end else begin
      o    = a[7:0] & 8'hFC;
      tx_w = we && is_mmio(a) && o == 8'h00;
      st_w = we && is_mmio(a) && o == 8'h04;
      bad  = (!is_ram(a) && !is_mmio(a)) || (we && is_mmio(a) && o != 8'h00 && o != 8'h04);
      full = fq.size() == FIFO_DEPTH;
      pop  = fq.size() != 0 && rdy;
      if (pop) void'(fq.pop_front());
      if (st_w && wd[2]) ovf_m = 1'b0;
      if (tx_w) begin
        if (!full || pop) fq.push_back(wd[7:0]);
        else ovf_m = 1'b1;
      end
`ifdef DMEM_BUS_ERR_EN
      if (st_w && wd[3]) err_m = 1'b0;
      if (bad) begin
        if (!err_m) ea_m = a;
        err_m = 1'b1;
      end
`else
      if (bad) err_m = 1'b0;
`endif
      cyc_m = cyc_m + 64'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra;
    reset = 1'b1; addr = '0; MemWrite = 1'b0; writedata = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state: counter reads 0 first, FIFO empty, tx_data 0
    check_val("rst_tx_data", tx_data, 8'h00);
    step(MB + 32'(OFF_CYCLE_LO), 0, 0, 0);
    step(MB + 32'(OFF_STATUS), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(MB + 32'(OFF_CYCLE_LO), 0, 0, 0);

    // RAM: same-cycle read sees old word, next cycle the new one, byte offset ignored
    step(32'h10, 1, 32'h1111_1111, 0);
    step(32'h10, 1, 32'hDEAD_BEEF, 0);
    step(32'h10, 0, 0, 0);
    step(32'h13, 0, 0, 0);

    // Fill past full, check STATUS, drain in order, clear overflow
    for (int i = 0; i < 9; i++) step(MB, 1, 32'h41 + 32'(i), 0);
    step(MB + 32'(OFF_STATUS), 0, 0, 0);
    for (int i = 0; i < 8; i++) step(32'h0, 0, 0, 1);
    step(MB + 32'(OFF_STATUS), 0, 0, 1);
    step(MB + 32'(OFF_STATUS), 1, 32'h4, 0);
    step(MB + 32'(OFF_STATUS), 0, 0, 0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) step(MB, 1, 32'h60 + 32'(i), 0);
    step(MB, 1, 32'h5A, 1);
    step(MB + 32'(OFF_STATUS), 0, 0, 0);
    for (int i = 0; i < 8; i++) step(MB + 32'(OFF_STATUS), 0, 0, 1);

    // Backpressure on a single byte
    step(MB, 1, 32'h33, 0);
    for (int i = 0; i < 5; i++) step(32'h0, 0, 0, 0);
    step(32'h0, 0, 0, 1);
    step(MB + 32'(OFF_STATUS), 0, 0, 0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(MB, 1, 32'h70 + 32'(i), 0);
    step(32'h0, 0, 0, 0, 1);
    step(MB + 32'(OFF_STATUS), 0, 0, 0);
    step(MB + 32'(OFF_CYCLE_LO), 0, 0, 0);
    step(32'h10, 0, 0, 0);

    // Counter carry from low word into high word
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    cyc_m = 64'h0000_0000_FFFF_FFFF;
    addr = MB + 32'(OFF_CYCLE_LO); MemWrite = 1'b0; tx_ready = 1'b0;
    #1;
    check_val("cyc_lo_forced", ReadData, 32'hFFFF_FFFF);
    release dut.cycle_q;
    step(MB + 32'(OFF_CYCLE_LO), 0, 0, 0);
    step(MB + 32'(OFF_CYCLE_HI), 0, 0, 0);
    step(MB + 32'(OFF_CYCLE_LO), 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'($urandom_range(0, 255));
        1, 2:    ra = MB + 32'($urandom_range(0, 23));
        default: ra = $urandom();
      endcase
      step(ra, $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
